// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 scan controller.
//   state_e      : scan FSM states
//   CH_*         : bit position of each colour channel in the {r0,g0,b0,r1,g1,b1}
//                  packing used by both rd_data (BPP bits each) and hub_rgb (1 bit each)
//   COL_W/ROW_W/PLANE_W : index widths for the default 64x64, 4-bit panel
package hub75_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_BLANK,
    S_LATCH,
    S_DISPLAY
  } state_e;

  localparam int NUM_CH = 6;
  localparam int CH_R0  = 5;
  localparam int CH_G0  = 4;
  localparam int CH_B0  = 3;
  localparam int CH_R1  = 2;
  localparam int CH_G1  = 1;
  localparam int CH_B1  = 0;

  localparam int DEF_COLS    = 64;
  localparam int DEF_ROWS    = 32;
  localparam int DEF_BPP     = 4;
  localparam int DEF_BASE_ON = 16;

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  localparam int COL_W   = clog2_min1(DEF_COLS);
  localparam int ROW_W   = clog2_min1(DEF_ROWS);
  localparam int PLANE_W = clog2_min1(DEF_BPP);

endpackage

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan controller: for each row pair and bit plane, fetch COLS pixel pairs
// from the frame buffer, shift the selected plane bit into the panel, latch it,
// then light the row for BASE_ON<<plane cycles (binary-weighted modulation).
// Ports:
//   pll_clk, rst_n  : the only clock; asynchronous active-low reset
//   enable          : run the scan (sampled in IDLE and at the end of each plane)
//   rd_addr/rd_data : frame-buffer read port {row,col}, one cycle read latency
//   hub_clk, hub_lat, hub_oe_n, hub_addr, hub_rgb : panel interface, all registered
//   frame_start     : one-cycle pulse on the first shift cycle of row 0, plane 0
module hub75_scan_ctrl
  import hub75_pkg::*;
#(
  parameter  int COLS       = DEF_COLS,
  parameter  int ROWS       = DEF_ROWS,
  parameter  int BPP        = DEF_BPP,
  parameter  int BASE_ON    = DEF_BASE_ON,
  localparam int COL_BITS   = clog2_min1(COLS),
  localparam int ROW_BITS   = clog2_min1(ROWS),
  localparam int PLANE_BITS = clog2_min1(BPP)
) (
  input  logic                         pll_clk,
  input  logic                         rst_n,
  input  logic                         enable,
  output logic [ROW_BITS+COL_BITS-1:0] rd_addr,
  input  logic [NUM_CH*BPP-1:0]        rd_data,
  output logic                         hub_clk,
  output logic                         hub_lat,
  output logic                         hub_oe_n,
  output logic [ROW_BITS-1:0]          hub_addr,
  output logic [NUM_CH-1:0]            hub_rgb,
  output logic                         frame_start
);

  localparam int SHIFT_W = $clog2(2*COLS+2);
  localparam int DISP_W  = $clog2(BASE_ON << (BPP-1)) + 1;

  // Shift-phase landmarks: last read address, last valid read data, last cycle.
  localparam logic [SHIFT_W-1:0] K_LAST_RD   = SHIFT_W'(2*COLS-2);
  localparam logic [SHIFT_W-1:0] K_LAST_DATA = SHIFT_W'(2*COLS-1);
  localparam logic [SHIFT_W-1:0] K_LAST      = SHIFT_W'(2*COLS+1);

  state_e                       state_q, state_d;
  logic [SHIFT_W-1:0]           k_q, k_d;
  logic [DISP_W-1:0]            disp_q, disp_d;
  logic [ROW_BITS-1:0]          row_q, row_d;
  logic [PLANE_BITS-1:0]        plane_q, plane_d;

  logic [ROW_BITS+COL_BITS-1:0] rd_addr_q, rd_addr_d;
  logic                         hub_clk_q, hub_clk_d;
  logic                         hub_lat_q, hub_lat_d;
  logic                         hub_oe_n_q, hub_oe_n_d;
  logic [ROW_BITS-1:0]          hub_addr_q, hub_addr_d;
  logic [NUM_CH-1:0]            hub_rgb_q, hub_rgb_d;
  logic                         frame_start_q, frame_start_d;

  logic [DISP_W-1:0]            disp_last;
  logic [NUM_CH-1:0]            plane_bits;

  assign disp_last = DISP_W'((BASE_ON << plane_q) - 1);

  // Select bit `plane` out of each BPP-bit channel of the fetched pixel pair.
  always_comb begin
    plane_bits = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      for (int b = 0; b < BPP; b++) begin
        if (PLANE_BITS'(b) == plane_q) plane_bits[ch] = rd_data[ch*BPP + b];
      end
    end
  end

  // Next-state and counter logic.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d = state_q;
    k_d     = k_q;
    disp_d  = disp_q;
    row_d   = row_q;
    plane_d = plane_q;

    unique case (state_q)
      S_IDLE: begin
        row_d   = '0;
        plane_d = '0;
        k_d     = '0;
        if (enable) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (k_q == K_LAST) state_d = S_BLANK;
        else               k_d     = k_q + SHIFT_W'(1);
      end
      S_BLANK: state_d = S_LATCH;
      S_LATCH: begin
        state_d = S_DISPLAY;
        disp_d  = '0;
      end
      S_DISPLAY: begin
        if (disp_q == disp_last) begin
          k_d = '0;
          if (plane_q == PLANE_BITS'(BPP-1)) begin
            plane_d = '0;
            row_d   = (row_q == ROW_BITS'(ROWS-1)) ? '0 : row_q + ROW_BITS'(1);
          end else begin
            plane_d = plane_q + PLANE_BITS'(1);
          end
          if (enable) begin
            state_d = S_SHIFT;
          end else begin
            state_d = S_IDLE;
            row_d   = '0;
            plane_d = '0;
          end
        end else begin
          disp_d = disp_q + DISP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the *next* state/counters, so each output flop
  // shows the value belonging to the cycle that state_q/k_q describe.
  // hub_rgb is the exception: it captures rd_data in the cycle it is valid
  // (odd k), so it appears one cycle later, ahead of the hub_clk high cycle.
  always_comb begin
    rd_addr_d     = rd_addr_q;
    hub_addr_d    = hub_addr_q;
    hub_rgb_d     = hub_rgb_q;
    hub_clk_d     = (state_d == S_SHIFT) && k_d[0] && (k_d >= SHIFT_W'(3));
    hub_lat_d     = (state_d == S_LATCH);
    hub_oe_n_d    = (state_d != S_DISPLAY);
    frame_start_d = (state_d == S_SHIFT) && (k_d == '0) && (row_d == '0) && (plane_d == '0);

    if ((state_d == S_SHIFT) && !k_d[0] && (k_d <= K_LAST_RD))
      rd_addr_d = {row_d, COL_BITS'(k_d >> 1)};
    if ((state_q == S_SHIFT) && k_q[0] && (k_q <= K_LAST_DATA))
      hub_rgb_d = plane_bits;
    // Row address moves only in BLANK, where the panel is dark.
    if (state_q == S_BLANK)
      hub_addr_d = row_q;

    if (state_d == S_IDLE) begin
      rd_addr_d  = '0;
      hub_addr_d = '0;
      hub_rgb_d  = '0;
    end
  end

  always_ff @(posedge pll_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      k_q           <= '0;
      disp_q        <= '0;
      row_q         <= '0;
      plane_q       <= '0;
      rd_addr_q     <= '0;
      hub_clk_q     <= 1'b0;
      hub_lat_q     <= 1'b0;
      hub_oe_n_q    <= 1'b1;
      hub_addr_q    <= '0;
      hub_rgb_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values,
      // so the order of these lines does not matter.
      state_q       <= state_d;
      k_q           <= k_d;
      disp_q        <= disp_d;
      row_q         <= row_d;
      plane_q       <= plane_d;
      rd_addr_q     <= rd_addr_d;
      hub_clk_q     <= hub_clk_d;
      hub_lat_q     <= hub_lat_d;
      hub_oe_n_q    <= hub_oe_n_d;
      hub_addr_q    <= hub_addr_d;
      hub_rgb_q     <= hub_rgb_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign rd_addr     = rd_addr_q;
  assign hub_clk     = hub_clk_q;
  assign hub_lat     = hub_lat_q;
  assign hub_oe_n    = hub_oe_n_q;
  assign hub_addr    = hub_addr_q;
  assign hub_rgb     = hub_rgb_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Directed self-checking bench for hub75_scan_ctrl at default parameters.
// A one-cycle-latency frame-buffer model returns a hashed word per {row,col};
// each plane is walked cycle by cycle and compared against hand-derived timing.
`timescale 1ns/1ps
module tb_hub75_scan_ctrl;
  import hub75_pkg::*;

  localparam int COLS    = 64;
  localparam int ROWS    = 32;
  localparam int BPP     = 4;
  localparam int BASE_ON = 16;
  localparam int FRAME   = 24576;
  localparam logic [31:0] RST_EXP = 32'h0200_0000;  // only hub_oe_n set

  logic        pll_clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [10:0] rd_addr;
  logic [23:0] rd_data = '0;
  logic        hub_clk, hub_lat, hub_oe_n, frame_start;
  logic [4:0]  hub_addr;
  logic [5:0]  hub_rgb;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc_cnt = 0, fs_cnt = 0, lat_cnt = 0, lat_oe_bad = 0, addr_bad = 0;
  int fs_time [0:7];
  logic       lat_prev  = 1'b0;
  logic [4:0] addr_prev = '0;
  int lat_snap;

  hub75_scan_ctrl dut (
    .pll_clk     (pll_clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .hub_clk     (hub_clk),
    .hub_lat     (hub_lat),
    .hub_oe_n    (hub_oe_n),
    .hub_addr    (hub_addr),
    .hub_rgb     (hub_rgb),
    .frame_start (frame_start)
  );

  initial forever #5 pll_clk = ~pll_clk;

  function automatic logic [23:0] mem_word(input int r, input int c);
    logic [31:0] h;
    h = 32'(r*COLS + c + 1) * 32'h9E37_79B1;
    return h[31:8];
  endfunction

  function automatic logic [5:0] exp_rgb(input int r, input int c, input int p);
    logic [23:0] w;
    logic [5:0]  e;
    w = mem_word(r, c);
    for (int ch = 0; ch < NUM_CH; ch++) e[ch] = w[ch*BPP + p];
    return e;
  endfunction

  function automatic logic [31:0] outs();
    return {6'b0, hub_oe_n, hub_clk, hub_lat, frame_start, hub_addr, hub_rgb, rd_addr};
  endfunction

  // Frame buffer: data for the address presented in cycle t appears in t+1.
  always @(posedge pll_clk) rd_data <= mem_word(int'(rd_addr[10:6]), int'(rd_addr[5:0]));

  // Background monitors for the global panel rules.
  always @(negedge pll_clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (frame_start && fs_cnt < 8) begin
      fs_time[fs_cnt] <= cyc_cnt;
      fs_cnt          <= fs_cnt + 1;
    end
    lat_prev <= hub_lat;
    if (hub_lat && !lat_prev) lat_cnt <= lat_cnt + 1;
    if (hub_lat && !hub_oe_n) lat_oe_bad <= lat_oe_bad + 1;
    addr_prev <= hub_addr;
    if (hub_addr != addr_prev && !hub_oe_n) addr_bad <= addr_bad + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Entered at the negedge of the first SHIFT cycle (k=0); returns at the
  // negedge of the first cycle after DISPLAY. drop_at >= 0 clears enable at
  // that shift cycle.
  task automatic observe_plane(input int r, input int p, input int drop_at);
    int   edges, cyc, disp;
    logic prev_clk;
    edges = 0; cyc = 0; prev_clk = 1'b0;
    check($sformatf("frame_start r%0d p%0d", r, p), 32'(frame_start), (r == 0 && p == 0) ? 1 : 0);
    check($sformatf("rd_addr_k0 r%0d p%0d", r, p), 32'(rd_addr), 32'(r*COLS));
    while (hub_lat !== 1'b1 && cyc < 400) begin
      if (cyc == drop_at) enable = 1'b0;
      if (hub_clk && !prev_clk) begin
        if (edges < COLS)
          check($sformatf("rgb r%0d p%0d c%0d", r, p, edges), 32'(hub_rgb), 32'(exp_rgb(r, edges, p)));
        edges++;
      end
      prev_clk = hub_clk;
      @(negedge pll_clk);
      cyc++;
    end
    check($sformatf("lat_cycle r%0d p%0d", r, p), cyc, 131);
    check($sformatf("clk_edges r%0d p%0d", r, p), edges, COLS);
    check($sformatf("lat_oe_n r%0d p%0d", r, p), 32'(hub_oe_n), 1);
    @(negedge pll_clk);
    check($sformatf("lat_width r%0d p%0d", r, p), 32'(hub_lat), 0);
    check($sformatf("disp_addr r%0d p%0d", r, p), 32'(hub_addr), r);
    disp = 0;
    while (hub_oe_n === 1'b0 && disp < 300) begin
      @(negedge pll_clk);
      disp++;
    end
    check($sformatf("disp_len r%0d p%0d", r, p), disp, BASE_ON << p);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge pll_clk);
    check("reset_outs", outs(), RST_EXP);
    rst_n = 1'b1;
    @(negedge pll_clk);  // one IDLE cycle with enable, now at SHIFT k=0

    // Two full frames plus the first plane of the third: row wrap and period.
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < ROWS; r++)
        for (int p = 0; p < BPP; p++) observe_plane(r, p, -1);
    observe_plane(0, 0, -1);
    check("fs_count_2frames", fs_cnt, 3);
    check("frame_period_0", fs_time[1] - fs_time[0], FRAME);
    check("frame_period_1", fs_time[2] - fs_time[1], FRAME);

    // Walk to row 5 plane 2 and drop enable mid-shift.
    for (int p = 1; p < BPP; p++) observe_plane(0, p, -1);
    for (int r = 1; r < 5; r++)
      for (int p = 0; p < BPP; p++) observe_plane(r, p, -1);
    observe_plane(5, 0, -1);
    observe_plane(5, 1, -1);
    observe_plane(5, 2, 40);
    check("idle_after_drop", outs(), RST_EXP);
    repeat (5) @(negedge pll_clk);
    check("idle_hold", outs(), RST_EXP);

    enable = 1'b1;
    @(negedge pll_clk);
    observe_plane(0, 0, -1);
    check("fs_count_reenable", fs_cnt, 4);

    // Asynchronous reset in the middle of a shift.
    repeat (60) @(negedge pll_clk);
    check("rd_addr_k60", 32'(rd_addr), 30);
    lat_snap = lat_cnt;
    rst_n = 1'b0;
    #1;
    check("rst_async", outs(), RST_EXP);
    repeat (200) @(negedge pll_clk);
    check("no_lat_in_reset", lat_cnt, lat_snap);
    check("reset_hold", outs(), RST_EXP);

    check("lat_oe_overlap", lat_oe_bad, 0);
    check("addr_change_lit", addr_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hub75_scan_ctrl.md
# hub75_scan_ctrl

Scan controller for the 64x64 HUB75 LED panel, clocked from the 30 MHz PLL output. It reads pixel pairs from the frame buffer and shifts one bit plane of a row pair into the panel. It then latches the row and lights it for a binary-weighted on-time. Row pairs are scanned at 1/32 with BPP-bit colour per channel.

## Interface
- COLS, default 64: columns per row.
- ROWS, default 32: scanned row pairs; the panel has 2*ROWS lines.
- BPP, default 4: bits per colour channel, which is also the number of bit planes.
- BASE_ON, default 16: on-time of plane 0 in clock cycles.
- pll_clk, in, 1: system clock (30 MHz). This is the only clock.
- rst_n, in, 1: asynchronous, active-low reset. Externally released after PLL `locked`.
- enable, in, 1: run the scan.
- rd_addr, out, clog2(ROWS)+clog2(COLS): frame-buffer address {row, col}, registered.
- rd_data, in, 6*BPP: {r0,g0,b0,r1,g1,b1}, each BPP bits. Index 0 is the upper half (line row), index 1 is the lower half (line row+ROWS). Read latency is exactly 1 cycle.
- hub_clk, out, 1: panel shift clock.
- hub_lat, out, 1: panel latch.
- hub_oe_n, out, 1: panel output enable, active low.
- hub_addr, out, clog2(ROWS): panel row address.
- hub_rgb, out, 6: {r0,g0,b0,r1,g1,b1}, one bit each.
- frame_start, out, 1: one-cycle pulse at the start of each frame.

## Operation
- States are IDLE, SHIFT, BLANK, LATCH and DISPLAY.
- Indices:
  - `row` runs 0..ROWS-1.
  - `plane` runs 0..BPP-1. Plane order is plane-minor: all planes of row r, then row r+1.
- IDLE:
  - Outputs are held at their reset values.
  - `row` and `plane` are both 0.
  - If enable=1, go to SHIFT next cycle.
- SHIFT: counter k runs 0..2*COLS+1 (130 cycles).
  - rd_addr = {row, c} is driven during cycle 2c.
  - rd_data is valid at cycle 2c+1. Bit `plane` of each channel is registered into hub_rgb, so it is visible from cycle 2c+2.
  - hub_clk=1 only in cycle 2c+3; it is 0 otherwise.
  - This gives exactly COLS rising edges, with data stable for 1 cycle before each rising edge and during it.
  - frame_start=1 in the first SHIFT cycle when row=0 and plane=0.
- BLANK, 1 cycle: hub_addr <= row.
- LATCH, 1 cycle: hub_lat=1.
- DISPLAY: hub_oe_n=0 for exactly BASE_ON<<plane cycles.
- On DISPLAY exit:
  - If plane<BPP-1: plane++.
  - Else: plane=0 and row++. After ROWS-1, row wraps to 0.
  - If enable=1, go to SHIFT; else go to IDLE and reset row and plane to 0.
- hub_oe_n=1 in every state except DISPLAY.
- enable is sampled only in IDLE and at DISPLAY exit. Deasserting enable mid-row completes the current plane, then goes to IDLE.
- Reset values: state IDLE; hub_oe_n=1; all other outputs 0, including rd_addr and hub_addr.
- rst_n asserted in any state forces the reset values immediately (asynchronous). No partial latch is issued.

## Timing
- Per plane: 130 + 1 + 1 + (BASE_ON<<plane) cycles.
- With defaults:
  - Per row: 4*132 + 16*15 = 768 cycles.
  - Per frame: 32*768 = 24576 cycles, about 1221 Hz at 30 MHz.
- hub_clk period is 2 cycles, a 15 MHz effective shift rate with 1 high cycle per column.
- hub_lat high and hub_oe_n low are never concurrent.
- hub_addr changes only while hub_oe_n=1.
- Counter widths:
  - Shift counter: clog2(2*COLS+2).
  - Display counter: clog2(BASE_ON<<(BPP-1)) + 1.
  - No overflow is permitted at the parameter defaults.

## Structure
- Package `hub75_pkg` holds:
  - the state enum,
  - channel index constants for rd_data slicing,
  - derived-width localparams (COL_W, ROW_W, PLANE_W).
- No sub-module. A single FSM plus shift, display, row and plane counters fits in one module of about 200 lines.

## Test plan
- Reset: hold rst_n=0 with enable=1.
  - hub_oe_n=1 and all other outputs 0.
  - After release, first SHIFT cycle follows the first cycle with enable=1, with frame_start=1.
- Shift data: memory model with rd_data = f(row, col), 1-cycle latency.
  - Exactly 64 hub_clk rising edges per SHIFT.
  - Sampled hub_rgb at each edge equals bit `plane` of f(row, col) for col 0..63.
- Latch/OE:
  - One hub_lat pulse per plane, each with hub_oe_n=1.
  - DISPLAY lengths for planes 0..3 are 16, 32, 64, 128 cycles.
  - hub_addr is stable throughout DISPLAY.
- Wrap: run 2 frames.
  - hub_addr sequence is 0..31 then 0.
  - frame_start pulses exactly 24576 cycles apart.
- Enable drop: deassert enable during SHIFT of row 5, plane 2.
  - Plane 2 completes with a 64-cycle DISPLAY, then IDLE.
  - Re-enable restarts at row 0, plane 0 with frame_start.
- Reset mid-SHIFT: assert rst_n=0 at k=60.
  - Outputs reach reset values in the same cycle.
  - No hub_lat pulse occurs.
